// File: rtl/j1_loader.sv
// Boot loader and code-RAM arbiter for the j1 core: takes a count/words/checksum
// byte stream, writes the code RAM, and releases the CPU once the image verifies.
module j1_loader #(
  parameter int DEPTH = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  input  logic [12:0] code_addr,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  output logic        cpu_reset,
  output logic        load_err,
  output logic        load_done
);

  typedef enum logic [3:0] {
    HDR_LO, HDR_HI, DAT_LO, DAT_HI, WRITE, SUM_LO, SUM_HI, RUN, ERROR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state, state_next;
  logic [15:0] count, count_next;
  logic [7:0]  lo_byte, lo_next;
  logic [13:0] addr, addr_next;
  logic [15:0] csum, csum_next;
  logic [15:0] wdata, wdata_next;
  logic        ready_st;
  logic        accept;
  logic [13:0] addr_inc;
  logic [16:0] count_rx;

  assign addr_inc = addr + 14'd1;
  assign count_rx = {1'b0, rx_data, count[7:0]};

  always_comb begin
    ready_st = 1'b0;
    case (state)
      HDR_LO, HDR_HI, DAT_LO, DAT_HI, SUM_LO, SUM_HI: ready_st = 1'b1;
      default:                                        ready_st = 1'b0;
    endcase
  end

  // A reload edge swallows no byte: the sender keeps it for the restarted header.
  assign accept   = rx_valid & ready_st & ~reload;
  assign rx_ready = ready_st & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= HDR_LO;
      count   <= '0;
      lo_byte <= '0;
      addr    <= '0;
      csum    <= '0;
      wdata   <= '0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      lo_byte <= lo_next;
      addr    <= addr_next;
      csum    <= csum_next;
      wdata   <= wdata_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    lo_next    = lo_byte;
    addr_next  = addr;
    csum_next  = csum;
    wdata_next = wdata;
    case (state)
      HDR_LO: if (accept) begin
        count_next[7:0] = rx_data;
        addr_next       = '0;
        csum_next       = '0;
        state_next      = HDR_HI;
      end
      HDR_HI: if (accept) begin
        count_next[15:8] = rx_data;
        if (count_rx > DEPTH_W)
          state_next = ERROR;
        else if (count_rx == 17'd0)
          state_next = SUM_LO;
        else
          state_next = DAT_LO;
      end
      DAT_LO: if (accept) begin
        lo_next    = rx_data;
        state_next = DAT_HI;
      end
      DAT_HI: if (accept) begin
        wdata_next = {rx_data, lo_byte};
        state_next = WRITE;
      end
      WRITE: begin
        csum_next = csum ^ wdata;
        addr_next = addr_inc;
        // 14-bit counter lets a full 8192-word image reach its terminal count.
        if ({2'b00, addr_inc} == count)
          state_next = SUM_LO;
        else
          state_next = DAT_LO;
      end
      SUM_LO: if (accept) begin
        lo_next    = rx_data;
        state_next = SUM_HI;
      end
      SUM_HI: if (accept) begin
        if ({rx_data, lo_byte} == csum)
          state_next = RUN;
        else
          state_next = ERROR;
      end
      default: state_next = state;
    endcase
    if (reload) begin
      state_next = HDR_LO;
      addr_next  = '0;
      csum_next  = '0;
    end
  end

  assign ram_we    = (state == WRITE);
  assign ram_wdata = wdata;
  assign ram_addr  = (state == RUN) ? code_addr : addr[12:0];
  assign cpu_reset = (state != RUN);
  assign load_done = (state == RUN);
  assign load_err  = (state == ERROR);

endmodule

// File: tb/tb_j1_loader.sv
// Directed bench for j1_loader: table of whole-image loads plus hand-written
// sequences for header overflow, reload priority and async reset mid-load.
module tb_j1_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic [12:0] code_addr;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic        cpu_reset;
  logic        load_err;
  logic        load_done;

  j1_loader #(.DEPTH(8192)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .reload(reload), .code_addr(code_addr),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .cpu_reset(cpu_reset), .load_err(load_err), .load_done(load_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [15:0] seed;
    logic [15:0] sum_xor;
    bit          gaps;
    bit          exp_run;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] img [8192];
  logic [15:0] mem [8192];
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          wr_base = 0;
  int          order_err = 0;
  int          early_run = 0;
  bit          loading = 1'b0;

  // Bench-side RAM model and write-order tracker.
  always @(posedge clk) begin
    if (ram_we) begin
      if (ram_addr !== 13'(wr_cnt - wr_base)) order_err <= order_err + 1;
      mem[ram_addr] <= ram_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (loading && cpu_reset !== 1'b1) early_run <= early_run + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    @(negedge clk);
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      check_output("rx_ready_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_body(input int n, input logic [15:0] sum, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_byte(img[i][7:0], gaps);
      send_byte(img[i][15:8], gaps);
    end
    send_byte(sum[7:0], gaps);
    send_byte(sum[15:8], gaps);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check_output("reload_err_clear", 32'(load_err), 32'd0);
    check_output("reload_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic finish_checks(input int n, input bit exp_run, input int early_base);
    int bad;
    check_output("cpu_reset_end", 32'(cpu_reset), 32'(!exp_run));
    check_output("load_done_end", 32'(load_done), 32'(exp_run));
    check_output("load_err_end", 32'(load_err), 32'(!exp_run));
    check_output("rx_ready_end", 32'(rx_ready), 32'd0);
    check_output("write_count", 32'(wr_cnt - wr_base), 32'(n));
    check_output("write_order", 32'(order_err), 32'd0);
    check_output("early_release", 32'(early_run - early_base), 32'd0);
    bad = 0;
    for (int i = 0; i < n; i++) if (mem[i] !== img[i]) bad++;
    check_output("ram_contents", 32'(bad), 32'd0);
    if (exp_run) begin
      code_addr = 13'h0ABC;
      #1;
      check_output("fetch_pass", 32'(ram_addr), 32'h0ABC);
      check_output("run_no_we", 32'(ram_we), 32'd0);
      code_addr = 13'h0000;
    end
  endtask

  task automatic apply_stimulus(input int n, input logic [15:0] sum, input bit gaps, input bit exp_run);
    int early_base;
    wr_base    = wr_cnt;
    early_base = early_run;
    loading    = 1'b1;
    send_byte(8'(n), gaps);
    send_byte(8'(n >> 8), gaps);
    send_body(n, sum, gaps);
    loading = 1'b0;
    finish_checks(n, exp_run, early_base);
  endtask

  function automatic logic [15:0] img_xor(input int n);
    logic [15:0] s = 16'h0000;
    for (int i = 0; i < n; i++) s ^= img[i];
    return s;
  endfunction

  task automatic fill_img(input int n, input logic [15:0] seed);
    for (int i = 0; i < n; i++) img[i] = seed ^ 16'(i * 16'h9E37) ^ 16'(i >> 3);
  endtask

  initial begin
    int early_base;
    vecs[0] = '{0,    16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[1] = '{0,    16'h0000, 16'h0001, 1'b0, 1'b0};
    vecs[2] = '{1,    16'hA5A5, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{4,    16'h1111, 16'h8000, 1'b0, 1'b0};
    vecs[4] = '{16,   16'h3C3C, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{16,   16'hC3C3, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{8192, 16'h7E81, 16'h0000, 1'b0, 1'b1};

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0; code_addr = 13'h0000;
    #2;
    check_output("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_output("rst_ram_we", 32'(ram_we), 32'd0);
    check_output("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_output("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_output("rst_load_err", 32'(load_err), 32'd0);
    check_output("rst_load_done", 32'(load_done), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("post_rst_rx_ready", 32'(rx_ready), 32'd1);

    // Hand image: 0x8001 ^ 0x6000 ^ 0x0005 = 0xE004
    img[0] = 16'h8001; img[1] = 16'h6000; img[2] = 16'h0005;
    apply_stimulus(3, 16'hE004, 1'b0, 1'b1);
    do_reload();
    apply_stimulus(3, 16'hE005, 1'b0, 1'b0);
    do_reload();

    for (int v = 0; v < 7; v++) begin
      fill_img(vecs[v].n, vecs[v].seed);
      apply_stimulus(vecs[v].n, img_xor(vecs[v].n) ^ vecs[v].sum_xor, vecs[v].gaps, vecs[v].exp_run);
      do_reload();
    end

    // Oversized header: 0x2001 words
    wr_base = wr_cnt;
    send_byte(8'h01, 1'b0);
    send_byte(8'h20, 1'b0);
    check_output("ovf_err", 32'(load_err), 32'd1);
    check_output("ovf_rx_ready", 32'(rx_ready), 32'd0);
    check_output("ovf_writes", 32'(wr_cnt - wr_base), 32'd0);
    do_reload();

    // Reload during WRITE: write still happens, held byte becomes the new count low byte.
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    wr_base = wr_cnt;
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    check_output("write_state_we", 32'(ram_we), 32'd1);
    reload = 1'b1; rx_data = 8'h02; rx_valid = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check_output("reload_write_cnt", 32'(wr_cnt - wr_base), 32'd1);
    check_output("reload_write_data", 32'(mem[0]), 32'h1234);
    check_output("reload_addr_zero", 32'(ram_addr), 32'd0);
    check_output("reload_byte_held", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    wr_base = wr_cnt;
    early_base = early_run;
    img[0] = 16'hBEEF; img[1] = 16'h0F0F;
    send_byte(8'h00, 1'b0);
    send_body(2, 16'hB1E0, 1'b0);
    finish_checks(2, 1'b1, early_base);

    // Async reset between words 5 and 6, then a fresh 8-word load.
    do_reload();
    fill_img(8, 16'h5A00);
    wr_base = wr_cnt;
    early_base = early_run;
    loading = 1'b1;
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send_byte(img[i][7:0], 1'b0);
      send_byte(img[i][15:8], 1'b0);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_output("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_output("midrst_rx_ready", 32'(rx_ready), 32'd0);
    check_output("midrst_addr", 32'(ram_addr), 32'd0);
    check_output("midrst_writes", 32'(wr_cnt - wr_base), 32'd5);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    fill_img(8, 16'h0A5F);
    apply_stimulus(8, img_xor(8), 1'b0, 1'b1);
    check_output("midrst_no_release", 32'(early_run - early_base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
